// File: rtl/framed_0110_tx_if.sv
// Bundle for the framed 0110 transmitter: payload handshake, serial line and status.
// din/din_valid are driven by the source; din_ready, q, busy, stuff and state_dbg by the transmitter.
interface framed_0110_tx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              q;
  logic              busy;
  logic              stuff;
  logic [2:0]        state_dbg;

  modport master (output din, din_valid, input din_ready, q, busy, stuff, state_dbg);
  modport slave  (input din, din_valid, output din_ready, q, busy, stuff, state_dbg);
endinterface

// File: rtl/framed_0110_tx.sv
// Serial frame transmitter: 0110 sync, MSB-first payload, even parity, two stop bits,
// with bit stuffing so 0110 appears on the line only as a frame's sync pattern.
module framed_0110_tx #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  framed_0110_tx_if.slave bus
);
  localparam int RW = $clog2(DATA_W + 1);
  localparam logic [3:0] SYNC_PAT = 4'b0110;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, STOP} state_t;

  // state names the phase of the bit currently on q; a stuffed bit belongs to the
  // phase of the data/parity bit it delays.
  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic [RW-1:0]     rem, rem_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              par, par_n;
  logic [2:0]        h, h_n;
  logic              q, q_n;
  logic              stuff, stuff_n;
  logic              busy, busy_n;
  logic              rdy, rdy_n;
  logic              accept;
  logic              start;
  logic              payload;

  // Handshake: a word transfers on a rising edge with din_valid && din_ready; din_ready
  // is registered and high only in IDLE and in the second stop cycle.
  assign accept = bus.din_valid && rdy;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    sh_n    = sh;
    par_n   = par;
    q_n     = q;
    stuff_n = 1'b0;
    busy_n  = busy;
    start   = 1'b0;
    payload = 1'b0;

    case (state)
      IDLE: begin
        if (accept) start = 1'b1;
        else begin
          q_n    = 1'b1;
          busy_n = 1'b0;
        end
      end
      SYNC: begin
        if (cnt != 2'd3) begin
          cnt_n = cnt + 2'd1;
          // ~cnt_n maps bit position 0..3 onto SYNC_PAT[3..0], i.e. MSB first
          q_n   = SYNC_PAT[~cnt_n];
        end else begin
          state_n = DATA;
          payload = 1'b1;
        end
      end
      DATA: payload = 1'b1;
      PARITY: begin
        state_n = STOP;
        cnt_n   = 2'd0;
        q_n     = 1'b1;
      end
      STOP: begin
        if (cnt == 2'd0) begin
          cnt_n = 2'd1;
          q_n   = 1'b1;
        end else if (accept) begin
          start = 1'b1;
        end else begin
          state_n = IDLE;
          q_n     = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        q_n     = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    // h includes the bit now on q, so 011 means a 0 next would complete 0110.
    if (payload) begin
      if (h == 3'b011) begin
        q_n     = 1'b1;
        stuff_n = 1'b1;
      end else if (rem != '0) begin
        q_n   = sh[DATA_W-1];
        sh_n  = {sh[DATA_W-2:0], 1'b0};
        par_n = par ^ sh[DATA_W-1];
        rem_n = rem - RW'(1);
      end else begin
        q_n     = par;
        state_n = PARITY;
      end
    end

    if (start) begin
      state_n = SYNC;
      cnt_n   = 2'd0;
      q_n     = 1'b0;
      busy_n  = 1'b1;
      sh_n    = bus.din;
      par_n   = 1'b0;
      rem_n   = RW'(DATA_W);
    end

    h_n   = {h[1:0], q_n};
    rdy_n = (state_n == IDLE) || (state_n == STOP && cnt_n == 2'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
      rem   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      h     <= 3'b111;
      q     <= 1'b1;
      stuff <= 1'b0;
      busy  <= 1'b0;
      rdy   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      sh    <= sh_n;
      par   <= par_n;
      h     <= h_n;
      q     <= q_n;
      stuff <= stuff_n;
      busy  <= busy_n;
      rdy   <= rdy_n;
    end
  end

  assign bus.q         = q;
  assign bus.busy      = busy;
  assign bus.stuff     = stuff;
  assign bus.din_ready = rdy;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_framed_0110_tx.sv
// Bench for framed_0110_tx: directed frames from the bit-level frame table, reset abort,
// back-to-back timing, and random words recovered by a destuffing receiver model.
module tb_framed_0110_tx;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset;

  framed_0110_tx_if #(.DATA_W(DATA_W)) bus ();

  framed_0110_tx #(.DATA_W(DATA_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard state for the random phase
  logic [DATA_W-1:0] exp_q[$];
  bit                cur_bits[$];
  bit                cur_stf[$];
  logic [3:0]        det_hist;
  int                det_fires;
  int                n_frames;
  bit                mon_en = 1'b0;

  // Receiver model: check sync, drop stuffed bits after any 011, rebuild word and parity.
  task automatic process_frame();
    int len;
    int i;
    int got;
    int s;
    int bad;
    logic [2:0]        hist;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] w_exp;
    logic              par_bit;
    logic [3:0]        stopv;
    len = cur_bits.size();
    n_frames++;
    check("rnd_det", 32'(det_fires), 32'(1));
    check("rnd_len_min", 32'(len >= DATA_W + 7), 32'(1));
    if (len < DATA_W + 7) return;
    check("rnd_sync", 32'({cur_bits[0], cur_bits[1], cur_bits[2], cur_bits[3]}), 32'(4'b0110));
    hist = {cur_bits[1], cur_bits[2], cur_bits[3]};
    i = 4; got = 0; s = 0; bad = 0; word = '0; par_bit = 1'b0;
    while (got < DATA_W + 1 && i < len) begin
      if (hist == 3'b011) begin
        if (!(cur_bits[i] && cur_stf[i])) bad++;
        s++;
      end else begin
        if (cur_stf[i]) bad++;
        if (got < DATA_W) word = {word[DATA_W-2:0], cur_bits[i]};
        else par_bit = cur_bits[i];
        got++;
      end
      hist = {hist[1:0], cur_bits[i]};
      i++;
    end
    check("rnd_stuff", 32'(bad), 32'(0));
    check("rnd_len", 32'(len), 32'(DATA_W + 7 + s));
    check("rnd_parity", 32'(par_bit), 32'(^word));
    stopv = 4'b0000;
    if (i + 2 == len) stopv = {cur_bits[i], cur_bits[i+1], cur_stf[i], cur_stf[i+1]};
    check("rnd_stop", 32'(stopv), 32'(4'b1100));
    if (exp_q.size() > 0) begin
      w_exp = exp_q.pop_front();
      check("rnd_data", 32'(word), 32'(w_exp));
    end else begin
      check("rnd_extra_frame", 32'(1), 32'(0));
    end
  endtask

  // Line monitor with an overlapping 0110 detector over the whole stream
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.busy) begin
          cur_bits.push_back(bus.q);
          cur_stf.push_back(bus.stuff);
        end
        det_hist = {det_hist[2:0], bus.q};
        if (det_hist == 4'b0110) begin
          det_fires++;
          check("rnd_det_pos", 32'(cur_bits.size()), 32'(4));
        end
        if (!bus.busy && cur_bits.size() > 0) begin
          process_frame();
          cur_bits.delete();
          cur_stf.delete();
          det_fires = 0;
        end
      end
    end
  end

  // Offer w; returns at the negedge of the first sync cycle
  task automatic start_word(input logic [DATA_W-1:0] w, input bit hold);
    int waited;
    @(negedge clk);
    bus.din       = w;
    bus.din_valid = 1'b1;
    waited = 0;
    while (!bus.din_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check("accept_timeout", 32'(0), 32'(1));
    @(negedge clk);
    if (!hold) bus.din_valid = 1'b0;
  endtask

  task automatic expect_seq(input string name, input logic [31:0] bits,
                            input logic [31:0] stf, input int len);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      check({name, "_q"},     32'(bus.q),         32'(bits[len-1-i]));
      check({name, "_stuff"}, 32'(bus.stuff),     32'(stf[len-1-i]));
      check({name, "_busy"},  32'(bus.busy),      32'(1));
      check({name, "_rdy"},   32'(bus.din_ready), 32'(i == len - 1));
    end
  endtask

  task automatic idle_check(input string name);
    check({name, "_idle_q"},     32'(bus.q),         32'(1));
    check({name, "_idle_busy"},  32'(bus.busy),      32'(0));
    check({name, "_idle_rdy"},   32'(bus.din_ready), 32'(1));
    check({name, "_idle_stuff"}, 32'(bus.stuff),     32'(0));
  endtask

  initial begin
    int bad;
    int waited;
    logic [DATA_W-1:0] w;

    reset         = 1'b1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    #3;
    idle_check("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    idle_check("post_reset");

    // Directed frames: 0110 00000000 0 11 / 0110 11[1]111111 0 11 / 0110 0011[1]011[1]00 11
    start_word(8'h00, 1'b0);
    expect_seq("f00", 32'(15'b011000000000011), 32'(0), 15);
    @(negedge clk);
    idle_check("f00");

    start_word(8'hFF, 1'b0);
    expect_seq("fff", 32'(16'h6FFB), 32'(16'h0200), 16);
    @(negedge clk);
    idle_check("fff");

    start_word(8'h36, 1'b0);
    expect_seq("f36", 32'(17'b01100011101110011), 32'(17'b00000000100010000), 17);
    @(negedge clk);
    idle_check("f36");

    // Back-to-back: valid held high, next sync right after the last stop bit
    start_word(8'hFF, 1'b1);
    bus.din = 8'h00;
    expect_seq("b2b_a", 32'(16'h6FFB), 32'(16'h0200), 16);
    @(negedge clk);
    bus.din_valid = 1'b0;
    expect_seq("b2b_b", 32'(15'b011000000000011), 32'(0), 15);
    @(negedge clk);
    idle_check("b2b");

    // Reset in the middle of DATA aborts the frame at once
    start_word(8'h36, 1'b0);
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    idle_check("mid_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.q !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("no_resume", 32'(bad), 32'(0));

    // Random words, each frame separated by at least one idle cycle
    det_hist  = 4'b1111;
    det_fires = 0;
    n_frames  = 0;
    mon_en    = 1'b1;
    for (int k = 0; k < 200; k++) begin
      w = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      exp_q.push_back(w);
      start_word(w, 1'b0);
      waited = 0;
      while (bus.busy && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 100) check("busy_timeout", 32'(0), 32'(1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("rnd_frames", 32'(n_frames), 32'(200));
    check("rnd_left", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
